// File: rtl/result_drain_collector.sv
// Result-side collector for the 4x4 systolic PE array: drains the four row
// streams into a local tile and hands it downstream one row per valid/ready beat.
module result_drain_collector #(
  parameter int DW      = 8,
  parameter int OUT_LAT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  output logic            OutputSign,
  input  logic [DW-1:0]   shift_in_0,
  input  logic [DW-1:0]   shift_in_1,
  input  logic [DW-1:0]   shift_in_2,
  input  logic [DW-1:0]   shift_in_3,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [4*DW-1:0] res_data,
  output logic [1:0]      res_row,
  output logic            res_last,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, SEND} state_t;

  // Last value of the shared counter while in FLUSH.
  localparam logic [1:0] FLUSH_LAST = (OUT_LAT > 0) ? 2'(OUT_LAT - 1) : 2'd0;

  state_t        state, state_nxt;
  logic [1:0]    drain_cnt;
  logic [1:0]    cap_cnt;
  logic [1:0]    row_cnt;
  logic          cap_en;
  logic          xfer;
  logic [DW-1:0] row_in [4];
  logic [DW-1:0] tile   [4][4];

  always_comb begin
    row_in[0] = shift_in_0;
    row_in[1] = shift_in_1;
    row_in[2] = shift_in_2;
    row_in[3] = shift_in_3;
  end

  // NOTE: state and counters use non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt  = state;
    OutputSign = 1'b0;
    res_valid  = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE:  if (start) state_nxt = DRAIN;
      DRAIN: begin
        OutputSign = 1'b1;
        if (drain_cnt == 2'd3) state_nxt = (OUT_LAT == 0) ? SEND : FLUSH;
      end
      FLUSH: if (drain_cnt == FLUSH_LAST) state_nxt = SEND;
      SEND: begin
        res_valid = 1'b1;
        if (res_ready && row_cnt == 2'd3) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    xfer     = res_valid && res_ready;
    res_last = res_valid && (row_cnt == 2'd3);
  end

  // One counter serves both DRAIN beats and FLUSH wait cycles; it clears on
  // every state change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drain_cnt <= 2'd0;
    end else if ((state == DRAIN || state == FLUSH) && state_nxt == state) begin
      drain_cnt <= drain_cnt + 2'd1;
    end else begin
      drain_cnt <= 2'd0;
    end
  end

  // Capture window is the OutputSign window delayed by the array's output latency.
  generate
    if (OUT_LAT == 0) begin : g_no_lat
      assign cap_en = OutputSign;
    end else begin : g_lat
      logic [OUT_LAT-1:0] os_dly;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) os_dly <= '0;
        else       os_dly <= (os_dly << 1) | OUT_LAT'(OutputSign);
      end
      assign cap_en = os_dly[OUT_LAT-1];
    end
  endgenerate

  // NOTE: the tile is a small register array that must read as zero after
  // reset, so it is reset like any other flop; a real RAM would not be.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_cnt <= 2'd0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tile[r][c] <= '0;
    end else if (cap_en) begin
      cap_cnt <= cap_cnt + 2'd1;
      for (int k = 0; k < 4; k++)
        tile[k][~cap_cnt] <= row_in[k];  // beat j lands in column 3-j
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_cnt <= 2'd0;
      done    <= 1'b0;
    end else begin
      done <= xfer && (row_cnt == 2'd3);
      if (xfer) row_cnt <= row_cnt + 2'd1;
    end
  end

  always_comb begin
    res_row  = row_cnt;
    res_data = '0;
    if (res_valid)
      res_data = {tile[row_cnt][3], tile[row_cnt][2], tile[row_cnt][1], tile[row_cnt][0]};
  end

endmodule

// File: tb/tb_result_drain_collector.sv
// Directed bench for result_drain_collector: three builds (OUT_LAT 1, 0, 3)
// fed by a behavioural PE-array output model, checked cycle by cycle.
module tb_result_drain_collector;

  localparam int LAT [3] = '{1, 0, 3};

  logic        clk = 1'b0;
  logic        rstn;
  logic        st   [3];
  logic        rdy  [3];
  logic        os   [3];
  logic [7:0]  sin  [3][4];
  logic        rv   [3];
  logic [31:0] rd   [3];
  logic [1:0]  rr   [3];
  logic        rl   [3];
  logic        bz   [3];
  logic        dn   [3];

  int n_checks = 0;
  int n_fail   = 0;
  int tile_mode;

  // Array model state: beat counter and OutputSign/beat history per build.
  int   bc [3];
  logic vh [3][4];
  int   bh [3][4];

  always #5 clk = ~clk;

  result_drain_collector #(.DW(8), .OUT_LAT(1)) u_dut (
    .clk(clk), .rstn(rstn), .start(st[0]), .OutputSign(os[0]),
    .shift_in_0(sin[0][0]), .shift_in_1(sin[0][1]), .shift_in_2(sin[0][2]), .shift_in_3(sin[0][3]),
    .res_valid(rv[0]), .res_ready(rdy[0]), .res_data(rd[0]), .res_row(rr[0]),
    .res_last(rl[0]), .busy(bz[0]), .done(dn[0])
  );

  result_drain_collector #(.DW(8), .OUT_LAT(0)) u_dut_lat0 (
    .clk(clk), .rstn(rstn), .start(st[1]), .OutputSign(os[1]),
    .shift_in_0(sin[1][0]), .shift_in_1(sin[1][1]), .shift_in_2(sin[1][2]), .shift_in_3(sin[1][3]),
    .res_valid(rv[1]), .res_ready(rdy[1]), .res_data(rd[1]), .res_row(rr[1]),
    .res_last(rl[1]), .busy(bz[1]), .done(dn[1])
  );

  result_drain_collector #(.DW(8), .OUT_LAT(3)) u_dut_lat3 (
    .clk(clk), .rstn(rstn), .start(st[2]), .OutputSign(os[2]),
    .shift_in_0(sin[2][0]), .shift_in_1(sin[2][1]), .shift_in_2(sin[2][2]), .shift_in_3(sin[2][3]),
    .res_valid(rv[2]), .res_ready(rdy[2]), .res_data(rd[2]), .res_row(rr[2]),
    .res_last(rl[2]), .busy(bz[2]), .done(dn[2])
  );

  function automatic logic [7:0] elem(input int mode, input int k, input int c);
    case (mode)
      1:       return 8'hFF;
      2:       return 8'(128 + 16 * k + c);
      default: return 8'(16 * k + c);
    endcase
  endfunction

  function automatic logic [31:0] exp_row(input int mode, input int r);
    return {elem(mode, r, 3), elem(mode, r, 2), elem(mode, r, 1), elem(mode, r, 0)};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        bc[i] <= 0;
        for (int d = 0; d < 4; d++) begin
          vh[i][d] <= 1'b0;
          bh[i][d] <= 0;
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bc[i]    <= os[i] ? bc[i] + 1 : 0;
        vh[i][1] <= os[i];
        bh[i][1] <= bc[i];
        for (int d = 2; d < 4; d++) begin
          vh[i][d] <= vh[i][d-1];
          bh[i][d] <= bh[i][d-1];
        end
      end
    end
  end

  // Beat j shows up LAT cycles after its OutputSign cycle carrying column 3-j;
  // outside that window the rows carry junk that must not be captured.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) sin[i][k] = 8'hEE;
      if ((LAT[i] == 0) ? os[i] : vh[i][LAT[i]])
        for (int k = 0; k < 4; k++)
          sin[i][k] = elem(tile_mode, k, 3 - ((LAT[i] == 0) ? bc[i] : bh[i][LAT[i]]));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " OutputSign"}, 32'(os[0]), 32'd0);
    check({tag, " res_valid"},  32'(rv[0]), 32'd0);
    check({tag, " res_last"},   32'(rl[0]), 32'd0);
    check({tag, " busy"},       32'(bz[0]), 32'd0);
    check({tag, " done"},       32'(dn[0]), 32'd0);
    check({tag, " res_row"},    32'(rr[0]), 32'd0);
    check({tag, " res_data"},   rd[0],      32'd0);
  endtask

  // Cycle 0 is the first loop cycle; starts, stalls and tile switches are
  // given relative to it. A small reference model tracks the expected drain.
  task automatic run_case(input string name, input int idx, input logic [31:0] start_mask,
                          input int stall_from, input int stall_len, input int mode0,
                          input int switch_cyc, input int mode1, input int ncyc,
                          input int bursts);
    int lat = LAT[idx];
    int s = -1, row = 4, done_at = -1, dmode = mode0;
    int os_cnt = 0, xfer_cnt = 0;
    bit idle_exp, exp_os, exp_rv;
    tile_mode = mode0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (c == switch_cyc) tile_mode = mode1;
      st[idx]  = (c < 32) ? start_mask[c] : 1'b0;
      rdy[idx] = !(c >= stall_from && c < stall_from + stall_len);
      #1;
      idle_exp = (row == 4);
      exp_os   = (s >= 0) && (c > s) && (c <= s + 4);
      exp_rv   = (s >= 0) && (row < 4) && (c >= s + 5 + lat);
      check($sformatf("%s c%0d OutputSign", name, c), 32'(os[idx]), 32'(exp_os));
      check($sformatf("%s c%0d res_valid", name, c),  32'(rv[idx]), 32'(exp_rv));
      check($sformatf("%s c%0d res_last", name, c),   32'(rl[idx]), 32'(exp_rv && row == 3));
      check($sformatf("%s c%0d busy", name, c),       32'(bz[idx]), 32'(!idle_exp));
      check($sformatf("%s c%0d done", name, c),       32'(dn[idx]), 32'(c == done_at));
      if (exp_rv) begin
        check($sformatf("%s c%0d res_data", name, c), rd[idx], exp_row(dmode, row));
        check($sformatf("%s c%0d res_row", name, c),  32'(rr[idx]), 32'(row));
      end
      os_cnt += int'(os[idx]);
      if (rv[idx] && rdy[idx]) xfer_cnt++;
      if (exp_rv && rdy[idx]) begin
        row++;
        if (row == 4) done_at = c + 1;
      end
      if (st[idx] && idle_exp) begin
        s     = c;
        row   = 0;
        dmode = tile_mode;
      end
    end
    st[idx]  = 1'b0;
    rdy[idx] = 1'b1;
    check({name, " OutputSign cycles"}, 32'(os_cnt), 32'(4 * bursts));
    check({name, " transfers"},         32'(xfer_cnt), 32'(4 * bursts));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    tile_mode = 0;
    for (int i = 0; i < 3; i++) begin
      st[i]  = 1'b0;
      rdy[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rstn = 1'b1;
    @(posedge clk);

    // Basic: OutputSign 1-4, rows 6-9, res_last at 9, done at 10.
    run_case("basic", 0, 32'h1, 99, 0, 0, -1, 0, 12, 1);
    check("basic row0 const", exp_row(0, 0), 32'h03020100);
    check("basic row3 const", exp_row(0, 3), 32'h33323130);

    // Row 1 stalled for 5 cycles; done moves from cycle 10 to 15.
    run_case("backpressure", 0, 32'h1, 7, 5, 0, -1, 0, 17, 1);

    // Extra starts at cycles 2 and 7 land while busy and are dropped.
    run_case("start_busy", 0, 32'h85, 99, 0, 0, -1, 0, 15, 1);

    // Second start in the done cycle (10) drains an all-0xFF tile.
    run_case("back2back", 0, 32'h401, 99, 0, 0, 10, 1, 22, 2);

    // Reset in the middle of DRAIN, then a fresh tile with distinct values.
    @(posedge clk); #1;
    tile_mode = 0;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst OutputSign before", 32'(os[0]), 32'd1);
    rstn = 1'b0;
    #1;
    check_zero("midrst async");
    @(posedge clk); #1;
    check_zero("midrst held");
    @(posedge clk); #1;
    rstn = 1'b1;
    run_case("after_reset", 0, 32'h1, 99, 0, 2, -1, 2, 12, 1);

    // Latency builds: first res_valid in cycle 5 and cycle 8.
    run_case("lat0", 1, 32'h1, 99, 0, 0, -1, 0, 11, 1);
    run_case("lat3", 2, 32'h1, 99, 0, 0, -1, 0, 14, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_drain_collector.md
# result_drain_collector

Consumer at the result end of the 4x4 systolic PE array. On a start request it asserts the array's result-shift enable (`OutputSign`) for four cycles and captures the four 8-bit row streams. It assembles the 4x4 result tile internally, then delivers it row by row over a valid/ready handshake to downstream logic (writeback or DMA). It is the read-side counterpart of the operand shift buffers that feed the array.

## Interface
- `DW`, 8, element width; must match the PE array row output width.
- `OUT_LAT`, 1, cycles from an `OutputSign` high cycle to its data appearing on the row outputs; legal range 0..3.

- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle drain request; honoured only in IDLE, ignored otherwise.
- `OutputSign`  out  1  result-shift enable to the PE array.
- `shift_in_0` .. `shift_in_3`  in  DW  row 0..3 result streams from the PE array.
- `res_valid`  out  1  a result row is offered.
- `res_ready`  in  1  downstream accepts the row; a transfer occurs when `res_valid && res_ready`.
- `res_data`  out  4*DW  result row: M[r][0] in bits [DW-1:0] up to M[r][3] in the MSBs.
- `res_row`  out  2  row index r of `res_data`.
- `res_last`  out  1  high together with row 3.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the row 3 transfer.

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - DRAIN: `OutputSign` high; a 2-bit shift counter runs 0..3.
  - FLUSH: waits out the remaining OUT_LAT capture cycles; skipped when OUT_LAT=0.
  - SEND: offers rows 0..3 in order.
- Transitions:
  - IDLE -> DRAIN when `start` is high.
  - DRAIN -> FLUSH (or -> SEND if OUT_LAT=0) after the 4th DRAIN cycle.
  - FLUSH -> SEND after OUT_LAT cycles.
  - SEND -> IDLE on the row 3 transfer.
- Array protocol: in drain beat j (j=0..3), `shift_in_k` carries element M[k][3-j]. The rightmost column exits first.
- Capture: a capture counter is enabled OUT_LAT cycles after the drain counter. On each capture edge, all four `shift_in_k` are written into the tile buffer at column 3-j. Exactly 16 elements are written per drain. Data on `shift_in_k` outside capture windows is ignored.
- SEND: `res_row` starts at 0 and increments on each transfer. `res_data`, `res_row` and `res_last` are held stable while `res_valid && !res_ready`. `res_valid` never drops without a transfer.
- `OutputSign` is never high outside DRAIN. Backpressure on `res_ready` never re-triggers a drain.
- The tile buffer is overwritten only by the next drain. Its contents after SEND are not guaranteed to downstream.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, both counters 0, tile buffer all 0.
  - `OutputSign`, `res_valid`, `res_last`, `busy`, `done` = 0.
  - `res_row` = 0, `res_data` = 0.
- With `start` sampled high at the edge ending cycle t:
  - `OutputSign` is high during cycles t+1..t+4.
  - Row data is captured at the ends of cycles t+1+OUT_LAT .. t+4+OUT_LAT.
  - `res_valid` first goes high in cycle t+5+OUT_LAT (t+6 with the default OUT_LAT).
- With `res_ready` held high, rows transfer on four consecutive cycles.
- `done` pulses in the cycle after the row 3 transfer. In that same cycle the block is in IDLE and `busy` is low, and a `start` in that cycle is accepted.
- Minimum start-to-start spacing is 9+OUT_LAT cycles.
- `start` while busy: no effect. It is not queued.
- `res_ready` high while `res_valid` is low: no effect.
- `rstn` low mid-DRAIN: `OutputSign` drops asynchronously. The partial tile is discarded and the array must be reloaded by upstream control.
- `rstn` low mid-SEND: `res_valid` drops and no `done` pulse is produced.

## Test plan
- Basic drain, OUT_LAT=1, `res_ready` tied high.
  - Stimulus: `start` at cycle 0; the array model drives M[k][c]=16k+c with column 3 first.
  - Required: `OutputSign` high in cycles 1-4; `res_valid` high in cycles 6-9.
  - Required: `res_data` row 0 = 0x03020100 and row 3 = 0x33323130; `res_last` only in cycle 9; `done` in cycle 10.
- Backpressure.
  - Stimulus: same tile, with `res_ready` low for 5 cycles at row 1.
  - Required: row 1 = 0x13121110 and `res_row`=1 held stable for all 5 cycles; no extra `OutputSign`; `done` arrives 5 cycles later than in the basic case.
- Start while busy.
  - Stimulus: `start` pulsed in cycles 2 and 7.
  - Required: only one 4-cycle `OutputSign` burst and exactly four transfers.
- Back-to-back.
  - Stimulus: `start` in the `done` cycle, with the second tile holding all 0xFF.
  - Required: a new burst starts the next cycle; all four rows of the second tile read 0xFFFFFFFF.
- Reset mid-operation.
  - Stimulus: `rstn` low in cycle 3 (mid-DRAIN), then released, then a fresh `start`.
  - Required: all outputs are 0 during reset; the fresh tile is delivered correctly with no stale elements.
- OUT_LAT=0 and OUT_LAT=3 builds.
  - Stimulus: the basic case on each build.
  - Required: `res_valid` first high in cycle 5 and cycle 8 respectively; data as in the basic case.
